phys_free_list: RTL and testbench



---
 rtl/phys_free_list.sv | 139 +++++++++++++
 tb/tb_phys_free_list.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// Free list of physical register tags: circular buffer with speculative head, committed head and dual-slot release.
// Define FREELIST_CHECK_EN to build the double-free checker that drives dbl_free_err.
module phys_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         alloc_req,
    output logic                         alloc_valid,
    output logic [$clog2(NUM_PREGS)-1:0] alloc_tag,
    input  logic                         free1_valid,
    input  logic [$clog2(NUM_PREGS)-1:0] free1_tag,
    input  logic                         free2_valid,
    input  logic [$clog2(NUM_PREGS)-1:0] free2_tag,
    input  logic                         commit_alloc,
    input  logic                         flush,
    output logic [$clog2(NUM_PREGS):0]   free_count,
    output logic                         overflow_err,
    output logic                         dbl_free_err
);
    localparam int TAG_W = $clog2(NUM_PREGS);
    localparam int PTR_W = TAG_W + 1;
    localparam logic [PTR_W-1:0] CAPACITY  = PTR_W'(NUM_PREGS);
    localparam logic [PTR_W-1:0] INIT_FREE = PTR_W'(NUM_PREGS - NUM_AREGS);

    logic [TAG_W-1:0] tag_buf [NUM_PREGS];
    logic [PTR_W-1:0] head, tail, commit_head;
    logic [PTR_W-1:0] head_next, tail_next, commit_head_next;
    logic [PTR_W-1:0] wr2_ptr, count_after1;
    logic             do_pop;
    logic             free1_live, free2_live;
    logic             acc1, acc2, ovf_hit;

    assign free_count  = tail - head;
    assign alloc_valid = (free_count != '0);
    assign alloc_tag   = tag_buf[head[TAG_W-1:0]];

    assign do_pop     = alloc_req && alloc_valid && !stall && !flush;
    assign free1_live = free1_valid && (free1_tag != '0);
    assign free2_live = free2_valid && (free2_tag != '0);

    // Capacity is judged against the current head; a same-cycle pop does not make room.
    assign acc1         = !stall && free1_live && (free_count < CAPACITY);
    assign count_after1 = free_count + PTR_W'(acc1);
    assign acc2         = !stall && free2_live && (count_after1 < CAPACITY);
    assign ovf_hit      = !stall && ((free1_live && !acc1) || (free2_live && !acc2));

    assign wr2_ptr          = tail + PTR_W'(acc1);
    assign tail_next        = wr2_ptr + PTR_W'(acc2);
    assign commit_head_next = commit_head + PTR_W'(commit_alloc && !stall);

    always_comb begin
        head_next = head;
        if (!stall) begin
            if (flush)
                head_next = commit_head_next;
            else if (do_pop)
                head_next = head + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            commit_head  <= '0;
            tail         <= INIT_FREE;
            overflow_err <= 1'b0;
        end else begin
            head        <= head_next;
            commit_head <= commit_head_next;
            tail        <= tail_next;
            if (ovf_hit)
                overflow_err <= 1'b1;
        end
    end

    // Tags above the architectural range start out free; the rest of the buffer is don't-care.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++)
                tag_buf[i] <= (i < NUM_PREGS - NUM_AREGS) ? TAG_W'(NUM_AREGS + i) : '0;
        end else begin
            if (acc1)
                tag_buf[tail[TAG_W-1:0]] <= free1_tag;
            if (acc2)
                tag_buf[wr2_ptr[TAG_W-1:0]] <= free2_tag;
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [NUM_PREGS-1:0] in_list, in_list_next;
    logic [PTR_W-1:0]     spec_span;
    logic [TAG_W-1:0]     slot_off;
    logic                 dbl_hit;

    // Shadow membership: a flush re-marks every tag between the committed head and the old head.
    always_comb begin
        in_list_next = in_list;
        spec_span    = head - commit_head_next;
        slot_off     = '0;
        dbl_hit      = 1'b0;
        if (!stall) begin
            if (do_pop)
                in_list_next[alloc_tag] = 1'b0;
            if (flush) begin
                for (int i = 0; i < NUM_PREGS; i++) begin
                    slot_off = TAG_W'(i) - commit_head_next[TAG_W-1:0];
                    if ({1'b0, slot_off} < spec_span)
                        in_list_next[tag_buf[i]] = 1'b1;
                end
            end
            if (acc1)
                in_list_next[free1_tag] = 1'b1;
            if (acc2)
                in_list_next[free2_tag] = 1'b1;
            dbl_hit = (free1_live && in_list[free1_tag])
                   || (free2_live && in_list[free2_tag])
                   || (free1_live && free2_live && (free1_tag == free2_tag));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++)
                in_list[i] <= (i >= NUM_AREGS);
            dbl_free_err <= 1'b0;
        end else begin
            in_list <= in_list_next;
            if (dbl_hit)
                dbl_free_err <= 1'b1;
        end
    end
`else
    assign dbl_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Scenario bench for phys_free_list; expected tags flow through a scoreboard queue.
module tb_phys_free_list;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stall = 1'b0;
    logic       alloc_req = 1'b0;
    logic       alloc_valid;
    logic [5:0] alloc_tag;
    logic       free1_valid = 1'b0;
    logic [5:0] free1_tag = '0;
    logic       free2_valid = 1'b0;
    logic [5:0] free2_tag = '0;
    logic       commit_alloc = 1'b0;
    logic       flush = 1'b0;
    logic [6:0] free_count;
    logic       overflow_err;
    logic       dbl_free_err;

    int         passed = 0;
    int         total = 0;
    logic [5:0] exp_q[$];
    logic [5:0] exp_tag;

    phys_free_list #(.NUM_PREGS(64), .NUM_AREGS(32)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
        .free1_valid(free1_valid), .free1_tag(free1_tag),
        .free2_valid(free2_valid), .free2_tag(free2_tag),
        .commit_alloc(commit_alloc), .flush(flush),
        .free_count(free_count), .overflow_err(overflow_err), .dbl_free_err(dbl_free_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; alloc_req = 1'b0; commit_alloc = 1'b0; flush = 1'b0;
        free1_valid = 1'b0; free1_tag = '0; free2_valid = 1'b0; free2_tag = '0;
    endtask

    task automatic apply_reset();
        idle();
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        reset = 1'b1;
        exp_q.delete();
    endtask

    // Pops n tags, comparing each against the scoreboard before the edge that consumes it.
    task automatic pop_n(input int n, input string name);
        alloc_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_tag = exp_q.pop_front();
            total++;
            if (alloc_valid !== 1'b1 || alloc_tag !== exp_tag)
                $display("FAIL %s[%0d]: valid=%0b tag=%0d, required valid=1 tag=%0d",
                         name, i, alloc_valid, alloc_tag, exp_tag);
            else passed++;
            step();
        end
        alloc_req = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (free_count !== 7'd32 || alloc_valid !== 1'b1 || alloc_tag !== 6'd32)
            $display("FAIL reset_state: count=%0d valid=%0b tag=%0d, required 32/1/32",
                     free_count, alloc_valid, alloc_tag);
        else passed++;
        total++;
        if (overflow_err !== 1'b0 || dbl_free_err !== 1'b0)
            $display("FAIL reset_flags: ovf=%0b dbl=%0b, required 0/0", overflow_err, dbl_free_err);
        else passed++;
    endtask

    task automatic test_drain();
        apply_reset();
        for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
        pop_n(32, "drain");
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        total++;
        if (alloc_valid !== 1'b0 || free_count !== 7'd0)
            $display("FAIL drain_empty: valid=%0b count=%0d, required 0/0", alloc_valid, free_count);
        else passed++;
    endtask

    task automatic test_empty_free();
        alloc_req = 1'b1; free1_valid = 1'b1; free1_tag = 6'd5;
        total++;
        if (alloc_valid !== 1'b0)
            $display("FAIL empty_before: valid=%0b, required 0", alloc_valid);
        else passed++;
        step();
        idle();
        total++;
        if (alloc_valid !== 1'b1 || alloc_tag !== 6'd5 || free_count !== 7'd1)
            $display("FAIL empty_push: valid=%0b tag=%0d count=%0d, required 1/5/1",
                     alloc_valid, alloc_tag, free_count);
        else passed++;
    endtask

    task automatic test_dual_free();
        apply_reset();
        free1_valid = 1'b1; free1_tag = 6'd7; free2_valid = 1'b1; free2_tag = 6'd9;
        step();
        idle();
        total++;
        if (free_count !== 7'd34)
            $display("FAIL dual_count: count=%0d, required 34", free_count);
        else passed++;
        for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
        exp_q.push_back(6'd7);
        exp_q.push_back(6'd9);
        pop_n(34, "dual_order");
        free1_valid = 1'b1; free1_tag = 6'd0; free2_valid = 1'b1; free2_tag = 6'd9;
        step();
        idle();
        total++;
        if (free_count !== 7'd1 || alloc_tag !== 6'd9)
            $display("FAIL zero_tag_drop: count=%0d tag=%0d, required 1/9", free_count, alloc_tag);
        else passed++;
    endtask

    task automatic test_flush();
        apply_reset();
        exp_q.push_back(6'd32); exp_q.push_back(6'd33); exp_q.push_back(6'd34);
        pop_n(3, "flush_pop");
        commit_alloc = 1'b1;
        step();
        flush = 1'b1; commit_alloc = 1'b1; alloc_req = 1'b1;
        step();
        idle();
        total++;
        if (alloc_tag !== 6'd34 || free_count !== 7'd30)
            $display("FAIL flush_restore: tag=%0d count=%0d, required 34/30", alloc_tag, free_count);
        else passed++;
        flush = 1'b1; free1_valid = 1'b1; free1_tag = 6'd3;
        step();
        idle();
        total++;
        if (alloc_tag !== 6'd34 || free_count !== 7'd31)
            $display("FAIL flush_with_free: tag=%0d count=%0d, required 34/31", alloc_tag, free_count);
        else passed++;
    endtask

    task automatic test_stall();
        apply_reset();
        exp_q.push_back(6'd32);
        pop_n(1, "stall_pop");
        stall = 1'b1; alloc_req = 1'b1; flush = 1'b1; commit_alloc = 1'b1;
        free1_valid = 1'b1; free1_tag = 6'd4;
        step();
        step();
        total++;
        if (free_count !== 7'd31 || alloc_tag !== 6'd33 || overflow_err !== 1'b0)
            $display("FAIL stall_hold: count=%0d tag=%0d ovf=%0b, required 31/33/0",
                     free_count, alloc_tag, overflow_err);
        else passed++;
        idle();
        flush = 1'b1;
        step();
        idle();
        total++;
        if (free_count !== 7'd32 || alloc_tag !== 6'd32)
            $display("FAIL stall_no_commit: count=%0d tag=%0d, required 32/32", free_count, alloc_tag);
        else passed++;
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            free1_valid = 1'b1; free1_tag = 6'(2 * i + 1);
            free2_valid = 1'b1; free2_tag = 6'(2 * i + 2);
            step();
        end
        idle();
        total++;
        if (free_count !== 7'd64 || overflow_err !== 1'b0)
            $display("FAIL fill_full: count=%0d ovf=%0b, required 64/0", free_count, overflow_err);
        else passed++;
        free1_valid = 1'b1; free1_tag = 6'd40;
        step();
        idle();
        total++;
        if (overflow_err !== 1'b1 || free_count !== 7'd64)
            $display("FAIL overflow_set: ovf=%0b count=%0d, required 1/64", overflow_err, free_count);
        else passed++;
        step(); step(); step();
        total++;
        if (overflow_err !== 1'b1 || alloc_tag !== 6'd32)
            $display("FAIL overflow_sticky: ovf=%0b tag=%0d, required 1/32", overflow_err, alloc_tag);
        else passed++;
    endtask

    task automatic test_reset_midop();
        alloc_req = 1'b1; free1_valid = 1'b1; free1_tag = 6'd11;
        step();
        reset = 1'b0;
        #1;
        total++;
        if (overflow_err !== 1'b0 || free_count !== 7'd32 || alloc_tag !== 6'd32)
            $display("FAIL async_reset: ovf=%0b count=%0d tag=%0d, required 0/32/32",
                     overflow_err, free_count, alloc_tag);
        else passed++;
        idle();
        step();
        reset = 1'b1;
    endtask

    task automatic test_dbl_free();
`ifdef FREELIST_CHECK_EN
        apply_reset();
        alloc_req = 1'b1;
        repeat (9) step();
        idle();
        free1_valid = 1'b1; free1_tag = 6'd40;
        step();
        idle();
        total++;
        if (dbl_free_err !== 1'b0)
            $display("FAIL dbl_first_free: dbl=%0b, required 0", dbl_free_err);
        else passed++;
        free1_valid = 1'b1; free1_tag = 6'd40;
        step();
        idle();
        total++;
        if (dbl_free_err !== 1'b1)
            $display("FAIL dbl_second_free: dbl=%0b, required 1", dbl_free_err);
        else passed++;
        apply_reset();
        free1_valid = 1'b1; free1_tag = 6'd5; free2_valid = 1'b1; free2_tag = 6'd5;
        step();
        idle();
        total++;
        if (dbl_free_err !== 1'b1)
            $display("FAIL dbl_same_slot: dbl=%0b, required 1", dbl_free_err);
        else passed++;
        apply_reset();
        alloc_req = 1'b1;
        repeat (9) step();
        idle();
        flush = 1'b1;
        step();
        idle();
        free1_valid = 1'b1; free1_tag = 6'd40;
        step();
        idle();
        total++;
        if (dbl_free_err !== 1'b1)
            $display("FAIL dbl_after_flush: dbl=%0b, required 1", dbl_free_err);
        else passed++;
`else
        apply_reset();
        alloc_req = 1'b1;
        repeat (9) step();
        idle();
        free1_valid = 1'b1; free1_tag = 6'd40;
        step();
        step();
        idle();
        total++;
        if (dbl_free_err !== 1'b0)
            $display("FAIL dbl_tied_off: dbl=%0b, required 0", dbl_free_err);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_drain();
        test_empty_free();
        test_dual_free();
        test_flush();
        test_stall();
        test_overflow();
        test_reset_midop();
        test_dbl_free();
        test_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
